// File: rtl/spi_uart_pkg.sv
// Shared types and constants for the SPI-to-UART bridge.
// Optional build macro used by the top: SPI_UART_LOOPBACK_EN.
package spi_uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] REPLY_RST = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/spi_to_uart_bridge_byte_fifo.sv
// byte_fifo: small synchronous FIFO of bytes between SPI capture and UART transmit.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo
  import spi_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [BYTE_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [BYTE_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents are only meaningful between the pointers.
  // NOTE: the data array has no reset -- occupancy is tracked by the pointers and
  // count, so clearing it would only add reset fan-out and block RAM inference.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_to_uart_bridge.sv
// spi_to_uart_bridge: SPI mode-0 slave whose received bytes are queued and handed
// to uart_tx via start/busy; MISO returns the most recent reply byte.
// Build macro SPI_UART_LOOPBACK_EN: reply register echoes completed SPI bytes
// instead of capturing uart_rx data. SYNC_STAGES must be at least 2.
module spi_to_uart_bridge
  import spi_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          mosi,
  input  logic                          cs,
  output logic                          miso,
  input  logic                          uart_done,
  input  logic [BYTE_W-1:0]             uart_data,
  output logic                          tx_start,
  output logic [BYTE_W-1:0]             tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   w_sclk_s, w_mosi_s, w_cs_s;
  logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  logic [BYTE_W-1:0]      r_rx_shift, r_tx_shift, r_reply, r_tx_data;
  logic [2:0]             r_bit_cnt;
  logic                   r_byte_valid, r_overflow;

  tx_state_t              r_state, w_state_next;
  logic                   w_pop, w_tx_start;
  logic [BYTE_W-1:0]      w_fifo_head;
  logic                   w_fifo_full, w_fifo_empty;

  // Synchronise the SPI pins and keep one extra copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s && !r_sclk_d;
  assign w_sclk_fall = !w_sclk_s && r_sclk_d;
  assign w_cs_rise   = w_cs_s && !r_cs_d;
  assign w_cs_fall   = !w_cs_s && r_cs_d;

  // MOSI capture: shift on each sclk rise, flag a complete byte on the 8th.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_cs_rise) begin
        r_bit_cnt <= '0;
      end else if (!w_cs_s && w_sclk_rise) begin
        r_rx_shift <= {r_rx_shift[BYTE_W-2:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        if (r_bit_cnt == 3'd7) r_byte_valid <= 1'b1;
      end
    end
  end

`ifdef SPI_UART_LOOPBACK_EN
  // Reply register echoes each completed SPI byte back to the master.
  always_ff @(posedge clk) begin
    if (!rst)              r_reply <= REPLY_RST;
    else if (r_byte_valid) r_reply <= r_rx_shift;
  end
`else
  // Reply register tracks the most recent byte received by uart_rx.
  always_ff @(posedge clk) begin
    if (!rst)           r_reply <= REPLY_RST;
    else if (uart_done) r_reply <= uart_data;
  end
`endif

  // MISO shifter: reload at cs fall and after each full byte, else shift on sclk fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_shift <= REPLY_RST;
    end else if (w_cs_fall) begin
      r_tx_shift <= r_reply;
    end else if (!w_cs_s && w_sclk_fall) begin
      if (r_bit_cnt == 3'd0) r_tx_shift <= r_reply;
      else                   r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
    end
  end

  assign miso = !w_cs_s && r_tx_shift[BYTE_W-1];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_byte_valid),
    .i_data  (r_rx_shift),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  // Sticky overflow: a completed byte arrived with no room and no simultaneous pop.
  always_ff @(posedge clk) begin
    if (!rst)                                          r_overflow <= 1'b0;
    else if (r_byte_valid && w_fifo_full && !w_pop)    r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;

  // TX FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // TX FSM next state and handshake outputs.
  // NOTE: every output of this block gets a default before the case, otherwise
  // paths that skip an assignment would infer latches.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_start   = 1'b0;
    case (r_state)
      IDLE:      if (!w_fifo_empty && !tx_busy) w_state_next = START;
      START: begin
        w_tx_start   = 1'b1;
        w_pop        = 1'b1;
        w_state_next = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy)  w_state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // tx_data latches the FIFO head on entry to START and holds for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst)                                          r_tx_data <= '0;
    else if (r_state == IDLE && w_state_next == START) r_tx_data <= w_fifo_head;
  end

  assign tx_start = w_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: doc/spi_to_uart_bridge.md
Name: spi_to_uart_bridge

Overview:
- Return-direction bridge: an SPI slave front end accepts bytes from an external SPI master and forwards them, in order, to a uart_tx instance through its start/busy handshake.
- Returns the most recent UART-received byte on MISO during the next SPI transfer.
- Sits between the external SPI pins and the existing uart_tx / uart_rx pair; all logic is in the single clk domain, with SPI pins oversampled.

Parameters:
- FIFO_DEPTH, 4: byte entries buffered between SPI capture and UART transmit; power of two, at least 2.
- SYNC_STAGES, 2: flip-flop stages synchronising sclk, mosi and cs into clk.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- sclk  input  1  SPI clock from external master, mode 0, asynchronous to clk
- mosi  input  1  SPI data in, MSB first
- cs  input  1  SPI chip select, active low
- miso  output  1  SPI data out, MSB first
- uart_done  input  1  one-cycle strobe from uart_rx
- uart_data  input  8  uart_rx byte, valid with uart_done
- tx_start  output  1  one-cycle start pulse to uart_tx
- tx_data  output  8  byte for uart_tx, stable from tx_start until tx_busy falls
- tx_busy  input  1  uart_tx busy
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst=0 at posedge clk):
  - miso=0, tx_start=0, tx_data=8'h00, fifo_count=0, overflow=0.
  - Reply register=8'h00, bit counter=0, FSM=IDLE, synchroniser flops=idle levels (sclk 0, cs 1).
  - Reset mid-transfer discards the partial byte and any FIFO contents. A pending uart_tx frame completes on its own; the FSM ignores it.
- Input sampling:
  - sclk, mosi and cs each pass through SYNC_STAGES flops.
  - Edges are detected against one additional registered copy.
  - sclk frequency must be ≤ clk/8.
- SPI receive:
  - While cs_sync=0, each sclk rising edge shifts mosi_sync into the shift register (MSB first) and increments a 3-bit counter.
  - When the 8th edge arrives, the assembled byte is pushed into the FIFO on the next clk.
  - The counter wraps to 0, so multi-byte transfers under one cs assertion are supported.
  - cs_sync rising resets the counter and discards any partial byte.
- SPI transmit (MISO):
  - On cs_sync falling, or at each byte boundary, the reply register is loaded into the MISO shift register, and miso presents bit 7.
  - Each sclk falling edge shifts out the next bit.
  - The reply register captures uart_data on every uart_done.
  - A capture during a byte takes effect at the next byte boundary.
  - miso=0 whenever cs_sync=1.
- FIFO:
  - Push when a byte completes and the FIFO is not full.
  - A push while full drops the byte and sets overflow; overflow clears only on reset.
  - Push and pop in the same cycle: both occur and count is unchanged. This also applies when full, so no overflow is flagged in that case.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - IDLE: if FIFO non-empty and tx_busy=0, go to START.
  - START: tx_start=1 for exactly one cycle; tx_data=FIFO head; pop; go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - Back-to-back bytes: the next tx_start comes 1 cycle after tx_busy falls plus 1 cycle in IDLE.
- Latency:
  - SPI pin edge to internal action: SYNC_STAGES+1 clk.
  - Byte complete to FIFO push: 1 clk.
  - Push to tx_start with the FIFO previously empty and FSM in IDLE: 2 clk.

Optional Feature:
- Macro SPI_UART_LOOPBACK_EN.
- Defined: the reply register loads each completed SPI byte instead of uart_data, so the SPI master reads back the previous byte it sent. uart_done and uart_data are ignored. UART forwarding is unchanged.
- Undefined: the reply register behaves as described above.

Decomposition:
- Package spi_uart_pkg holds:
  - the tx_state_t enum (IDLE, START, WAIT_BUSY, WAIT_DONE);
  - the BYTE_W=8 constant;
  - the reply reset value 8'h00.
- One sub-module, byte_fifo: synchronous FIFO parameterised by depth, with push, pop, full, empty and count.
- SPI edge detection and the FSM stay in the top module.

Test Plan:
- Reset check: hold rst=0 for 3 clk with random pins -> all outputs at reset values; release with cs=1 -> no tx_start.
- Single byte: master sends 8'h3C at clk/16 -> exactly one tx_start with tx_data=8'h3C, 2 clk after the FIFO push; fifo_count returns to 0 after the pop.
- Reply path: pulse uart_done with uart_data=8'hA5, then run a transfer -> master samples 8'hA5 on MISO; the slave-side byte is forwarded to uart_tx.
- Burst/overflow: with tx_busy held 1, send 6 bytes under one cs (8'h01..8'h06) at FIFO_DEPTH=4:
  - fifo_count=4 and overflow=1;
  - after busy releases, uart_tx receives 8'h01..8'h04 in order.
- Partial byte abort: cs rises after 5 bits, then a full 8'h81 -> only 8'h81 forwarded.
- Mid-transfer reset: assert rst after 4 bits -> FIFO empty, FSM IDLE; the next complete byte 8'h55 is forwarded correctly.
- With SPI_UART_LOOPBACK_EN: send 8'h11 then 8'h22 in one cs -> MISO returns 8'h00 then 8'h11.
